// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_SQUASH = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_NOP_INST = 16'h0800;
  localparam logic [15:0] PC_INC       = 16'd2;

  // Wraps modulo 2^16, so FFFE advances to 0000.
  function automatic logic [15:0] pc_plus_inc(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_unit_if;

  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_stall;

  modport master (
    output imem_rd, imem_addr,
    input  imem_data, imem_done, imem_stall
  );

  modport slave (
    input  imem_rd, imem_addr,
    output imem_data, imem_done, imem_stall
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Architectural PC register: synchronous reset to the boot address, load enable.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] pc_d,
  output logic [15:0] pc_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (load) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one read outstanding to a multi-cycle memory
// and hands fetched words to decode under valid/stall flow control.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter logic [15:0] NOP_INST = DEF_NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic [15:0]  next_pc,
  input  logic         redirect,
  input  logic         stall,
  input  logic         halt,
  output logic [15:0]  pc_current,
  output logic [15:0]  inst,
  output logic [15:0]  inst_pc2,
  output logic         inst_valid,
  output logic         err
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q;
  logic [15:0]  inst_q, inst_d;
  logic [15:0]  inst_pc2_q, inst_pc2_d;
  logic         inst_valid_q, inst_valid_d;
  logic         err_q, err_d;
  logic         halt_pend_q, halt_pend_d;
  logic         rd_req, capture, pc_load;
  logic         reg_free, eff_halt, do_redirect;

  assign reg_free    = !inst_valid_q || !stall;
  assign eff_halt    = halt || halt_pend_q;
  // Once halted only reset gets us out, so a late redirect is ignored there.
  assign do_redirect = redirect && (state_q != ST_HALTED);
  assign capture     = !do_redirect && !eff_halt && imem.imem_done &&
                       ((state_q == ST_WAIT) || rd_req);
  assign pc_load     = do_redirect || capture;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .pc_d (next_pc),
    .pc_q (pc_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      inst_q       <= NOP_INST;
      inst_pc2_q   <= 16'h0000;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc2_q   <= inst_pc2_d;
      inst_valid_q <= inst_valid_d;
      err_q        <= err_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    halt_pend_d = do_redirect ? 1'b0 : (halt_pend_q || halt);
    if (do_redirect) begin
      if ((state_q == ST_WAIT || state_q == ST_SQUASH) && !imem.imem_done) begin
        state_d = ST_SQUASH;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (eff_halt) begin
            state_d = ST_HALTED;
          end else if (inst_valid_q && stall) begin
            state_d = ST_HOLD;
          end else if (!imem.imem_stall) begin
            if (pc_q[0]) begin
              err_d   = 1'b1;
              state_d = ST_HALTED;
            end else if (!imem.imem_done) begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT, ST_SQUASH: begin
          if (imem.imem_done) begin
            state_d = eff_halt ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (eff_halt) begin
            state_d = ST_HALTED;
          end else if (!stall) begin
            state_d = ST_FETCH;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    rd_req       = !rst && (state_q == ST_FETCH) && !redirect && !eff_halt &&
                   !imem.imem_stall && reg_free && !pc_q[0];
    inst_d       = inst_q;
    inst_pc2_d   = inst_pc2_q;
    inst_valid_d = inst_valid_q;
    if (do_redirect) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end else if (capture) begin
      inst_valid_d = 1'b1;
      inst_d       = imem.imem_data;
      inst_pc2_d   = pc_plus_inc(pc_q);
    end else if (!stall) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end
  end

  assign imem.imem_rd   = rd_req;
  assign imem.imem_addr = pc_q;
  assign pc_current     = pc_q;
  assign inst           = inst_q;
  assign inst_pc2       = inst_pc2_q;
  assign inst_valid     = inst_valid_q;
  assign err            = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a latency-programmable
// memory and an in-order instruction-stream reference.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, halt, redirect;
  logic [15:0] next_pc;
  logic [15:0] pc_current, inst, inst_pc2;
  logic        inst_valid, err;

  fetch_unit_if imem_if ();

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_if),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .stall      (stall),
    .halt       (halt),
    .pc_current (pc_current),
    .inst       (inst),
    .inst_pc2   (inst_pc2),
    .inst_valid (inst_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          check_count = 0;
  int          fail_count  = 0;
  int          mem_lat     = 0;
  int          mem_count   = 0;
  logic        pending     = 1'b0;
  logic [15:0] pend_data   = 16'h0000;
  logic        override_en = 1'b0;
  logic [15:0] override_val = 16'h0000;
  logic        rd_seen, done_seen, valid_pre;
  logic [15:0] addr_seen, inst_pre, pc2_pre;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h4000 + (a >> 1) + 16'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    check_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, let the memory react to imem_rd, then cross the edge.
  task automatic applyStimulus(input logic rst_v, input logic stall_v,
                               input logic imst_v, input logic redir_v,
                               input logic halt_v, input logic [15:0] npc);
    rst = rst_v; stall = stall_v; redirect = redir_v; halt = halt_v;
    next_pc = npc;
    imem_if.imem_stall = imst_v;
    imem_if.imem_done  = 1'b0;
    #1;
    rd_seen   = imem_if.imem_rd;
    addr_seen = imem_if.imem_addr;
    valid_pre = inst_valid;
    inst_pre  = inst;
    pc2_pre   = inst_pc2;
    done_seen = 1'b0;
    if (rst_v) begin
      pending = 1'b0;
    end else if (pending) begin
      checkOutput("one_outstanding", {15'b0, rd_seen}, 16'h0000);
      mem_count--;
      if (mem_count == 0) begin
        imem_if.imem_done = 1'b1;
        imem_if.imem_data = pend_data;
        pending   = 1'b0;
        done_seen = 1'b1;
      end
    end else if (rd_seen && !imst_v) begin
      pend_data   = override_en ? override_val : mem_word(addr_seen);
      override_en = 1'b0;
      if (mem_lat == 0) begin
        imem_if.imem_done = 1'b1;
        imem_if.imem_data = pend_data;
        done_seen = 1'b1;
      end else begin
        pending   = 1'b1;
        mem_count = mem_lat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] model_pc, cons_pc;
    int fetched_n, cons_n;
    logic stall_r, imst_r;

    imem_if.imem_data = 16'h0000;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    checkOutput("rst_rd", {15'b0, rd_seen}, 16'h0000);
    checkOutput("rst_pc", pc_current, 16'h0000);
    checkOutput("rst_valid", {15'b0, inst_valid}, 16'h0000);
    checkOutput("rst_inst", inst, 16'h0800);
    checkOutput("rst_pc2", inst_pc2, 16'h0000);
    checkOutput("rst_err", {15'b0, err}, 16'h0000);

    // Zero-wait memory
    mem_lat = 0;
    applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    checkOutput("zw_rd0", {15'b0, rd_seen}, 16'h0001);
    checkOutput("zw_inst0", inst, 16'h4001);
    checkOutput("zw_pc2_0", inst_pc2, 16'h0002);
    checkOutput("zw_valid0", {15'b0, inst_valid}, 16'h0001);
    applyStimulus(0, 0, 0, 0, 0, 16'h0004);
    checkOutput("zw_addr1", addr_seen, 16'h0002);
    checkOutput("zw_inst1", inst, 16'h4002);
    checkOutput("zw_pc2_1", inst_pc2, 16'h0004);
    checkOutput("zw_pc", pc_current, 16'h0004);

    // 3-cycle latency with decode stall
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    mem_lat = 3;
    applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    checkOutput("lat_wait_valid", {15'b0, inst_valid}, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    checkOutput("lat_inst", inst, 16'h4001);
    checkOutput("lat_valid", {15'b0, inst_valid}, 16'h0001);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'h0004);
      checkOutput("stall_rd", {15'b0, rd_seen}, 16'h0000);
      checkOutput("stall_inst", inst, 16'h4001);
    end
    applyStimulus(0, 0, 0, 0, 0, 16'h0004);
    checkOutput("unstall_rd", {15'b0, rd_seen}, 16'h0000);
    checkOutput("consumed_valid", {15'b0, inst_valid}, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0004);
    checkOutput("resume_rd", {15'b0, rd_seen}, 16'h0001);
    checkOutput("resume_addr", addr_seen, 16'h0002);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0004);
    checkOutput("lat_inst2", inst, 16'h4002);

    // Redirect while a read is outstanding
    override_en = 1'b1; override_val = 16'hDEAD;
    applyStimulus(0, 0, 0, 0, 0, 16'h0006);
    applyStimulus(0, 0, 0, 1, 0, 16'h0100);
    checkOutput("redir_pc", pc_current, 16'h0100);
    checkOutput("redir_valid", {15'b0, inst_valid}, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0102);
    checkOutput("squash_rd", {15'b0, rd_seen}, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0102);
    checkOutput("squash_done", {15'b0, done_seen}, 16'h0001);
    checkOutput("squash_valid", {15'b0, inst_valid}, 16'h0000);
    mem_lat = 0;
    applyStimulus(0, 0, 0, 0, 0, 16'h0102);
    checkOutput("redir_addr", addr_seen, 16'h0100);
    checkOutput("redir_inst", inst, 16'h4081);

    // Redirect coincident with imem_done
    mem_lat = 2;
    applyStimulus(0, 0, 0, 0, 0, 16'h0104);
    applyStimulus(0, 0, 0, 0, 0, 16'h0104);
    applyStimulus(0, 0, 0, 1, 0, 16'h0200);
    checkOutput("coinc_done", {15'b0, done_seen}, 16'h0001);
    checkOutput("coinc_valid", {15'b0, inst_valid}, 16'h0000);
    checkOutput("coinc_pc", pc_current, 16'h0200);
    mem_lat = 0;
    applyStimulus(0, 0, 0, 0, 0, 16'h0202);
    checkOutput("coinc_addr", addr_seen, 16'h0200);
    checkOutput("coinc_inst", inst, 16'h4101);

    // Misaligned PC
    applyStimulus(0, 0, 0, 0, 0, 16'h0003);
    checkOutput("mis_pc", pc_current, 16'h0003);
    applyStimulus(0, 0, 0, 0, 0, 16'h0005);
    checkOutput("mis_rd", {15'b0, rd_seen}, 16'h0000);
    checkOutput("mis_err", {15'b0, err}, 16'h0001);
    applyStimulus(0, 0, 0, 0, 0, 16'h0005);
    checkOutput("mis_err_sticky", {15'b0, err}, 16'h0001);
    checkOutput("mis_rd2", {15'b0, rd_seen}, 16'h0000);

    // PC wrap-around
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    checkOutput("wrap_rst_err", {15'b0, err}, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'hFFFE);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOutput("wrap_addr", addr_seen, 16'hFFFE);
    checkOutput("wrap_pc2", inst_pc2, 16'h0000);
    checkOutput("wrap_inst", inst, 16'hC000);
    checkOutput("wrap_err", {15'b0, err}, 16'h0000);

    // Halt with a read outstanding
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    mem_lat = 3;
    applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    applyStimulus(0, 0, 0, 0, 1, 16'h0002);
    applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    checkOutput("halt_done", {15'b0, done_seen}, 16'h0001);
    checkOutput("halt_valid", {15'b0, inst_valid}, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 16'h0002);
      checkOutput("halted_rd", {15'b0, rd_seen}, 16'h0000);
    end
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    mem_lat = 0;
    applyStimulus(0, 0, 0, 0, 0, 16'h0002);
    checkOutput("halt_exit_rd", {15'b0, rd_seen}, 16'h0001);

    // Randomized flow control against an in-order stream model
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    model_pc = 16'h0000; cons_pc = 16'h0000;
    fetched_n = 0; cons_n = 0;
    for (int i = 0; i < 400; i++) begin
      stall_r = ($urandom_range(0, 9) < 3);
      imst_r  = ($urandom_range(0, 3) == 0);
      mem_lat = $urandom_range(0, 3);
      applyStimulus(0, stall_r, imst_r, 0, 0, model_pc + 16'd2);
      if (valid_pre && !stall_r) begin
        checkOutput("rnd_inst", inst_pre, mem_word(cons_pc));
        checkOutput("rnd_pc2", pc2_pre, cons_pc + 16'd2);
        cons_pc = cons_pc + 16'd2;
        cons_n++;
      end
      if (rd_seen) begin
        checkOutput("rnd_addr", addr_seen, model_pc);
        checkOutput("rnd_rd_imstall", {15'b0, imst_r}, 16'h0000);
      end
      if (done_seen) begin
        model_pc = model_pc + 16'd2;
        fetched_n++;
      end
    end
    checkOutput("rnd_progress", {15'b0, (cons_n >= 20)}, 16'h0001);
    checkOutput("rnd_no_drop", {15'b0, ((fetched_n - cons_n) <= 1)}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
